// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, default timing, command bytes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQUEST   = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5,
        ERROR     = 3'd6
    } ps2_state_e;

    // Defaults assume a 50 MHz clk.
    localparam int DEF_INHIBIT_CYCLES = 6000;
    localparam int DEF_START_TIMEOUT  = 750000;
    localparam int DEF_XFER_TIMEOUT   = 100000;
    localparam int DEF_CNT_W          = 20;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    // PS/2 frames carry odd parity: data plus parity has an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
// Latency: n/a (wires only).
// Backpressure: tx_start is dropped unless the transmitter is idle (busy low).
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output tx_data,
        output tx_start,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output busy,
        output done,
        output error
    );

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for a raw PS/2 pin plus a falling-edge strobe.
// Latency: sync follows the pin after 2 clk; fall is acted on 3 clk after the pin drops.
// Backpressure: none, free-running.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync,
    output logic fall
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Reset to the idle-high line level so leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], pin};
            prev_q <= sync_q[1];
        end
    end

    assign sync = sync_q[1];
    assign fall = prev_q & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11 device-clocked bits, ACK check.
// Latency: INHIBIT_CYCLES plus the device-paced frame; done/error pulse one clk after the end.
// Backpressure: tx_start is accepted only in IDLE and never queued; busy covers the transfer.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
    parameter int XFER_TIMEOUT   = DEF_XFER_TIMEOUT,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave host,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LAST    = CNT_W'(XFER_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX    = {CNT_W{1'b1}};

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] timer_q;
    logic [3:0]       bit_cnt_q;
    logic [9:0]       shreg_q;
    logic             tx_bit_q;
    logic             done_q;

    logic clk_sync, clk_fall;
    logic data_sync, data_fall_unused;

    logic timer_clr, cnt_clr, cnt_inc, load, shift_en, done_set;
    logic busy, err;

    ps2_sync_edge u_clk_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (ps2_clk_in),
        .sync (clk_sync),
        .fall (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (ps2_data_in),
        .sync (data_sync),
        .fall (data_fall_unused)
    );

    // Within each state a device clock edge is tested before the timeout, so the edge wins a tie.
    always_comb begin
        state_d     = state_q;
        timer_clr   = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        load        = 1'b0;
        shift_en    = 1'b0;
        done_set    = 1'b0;
        busy        = 1'b1;
        err         = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (host.tx_start) begin
                    load      = 1'b1;
                    timer_clr = 1'b1;
                    cnt_clr   = 1'b1;
                    state_d   = INHIBIT;
                end
            end

            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (timer_q >= INHIBIT_LAST) begin
                    timer_clr = 1'b1;
                    state_d   = REQUEST;
                end
            end

            REQUEST: begin
                ps2_data_oe = 1'b1;
                if (clk_fall) begin
                    shift_en  = 1'b1;
                    cnt_inc   = 1'b1;
                    timer_clr = 1'b1;
                    state_d   = SHIFT;
                end else if (timer_q >= START_LAST) begin
                    state_d = ERROR;
                end
            end

            // Edges 2..10 shift out d1..d7, parity, then the stop bit (release).
            SHIFT: begin
                ps2_data_oe = ~tx_bit_q;
                if (clk_fall) begin
                    shift_en = 1'b1;
                    cnt_inc  = 1'b1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ACK;
                    end
                end else if (timer_q >= XFER_LAST) begin
                    state_d = ERROR;
                end
            end

            ACK: begin
                if (clk_fall) begin
                    cnt_inc = 1'b1;
                    state_d = data_sync ? ERROR : WAIT_IDLE;
                end else if (timer_q >= XFER_LAST) begin
                    state_d = ERROR;
                end
            end

            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_set = 1'b1;
                    state_d  = IDLE;
                end else if (timer_q >= XFER_LAST) begin
                    state_d = ERROR;
                end
            end

            ERROR: begin
                busy    = 1'b0;
                err     = 1'b1;
                state_d = IDLE;
            end

            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx_bit_q  <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_set;

            if (timer_clr) begin
                timer_q <= '0;
            end else if (timer_q != TIMER_MAX) begin
                timer_q <= timer_q + 1'b1;
            end

            if (cnt_clr) begin
                bit_cnt_q <= '0;
            end else if (cnt_inc) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end

            // Frame is {stop, parity, d7..d0}; ones shifted in keep the line released.
            if (load) begin
                shreg_q <= {1'b1, odd_parity(host.tx_data), host.tx_data};
            end else if (shift_en) begin
                tx_bit_q <= shreg_q[0];
                shreg_q  <= {1'b1, shreg_q[9:1]};
            end
        end
    end

    assign host.busy  = busy;
    assign host.done  = done_q;
    assign host.error = err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, clocking PS/2 device model, frame model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 10;
    localparam int ST   = 200;
    localparam int XF   = 2000;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if hif ();

    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    wire  ps2_clk_pin  = dev_clk & ~ps2_clk_oe;
    wire  ps2_data_pin = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (ST),
        .XFER_TIMEOUT   (XF),
        .CNT_W          (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (hif),
        .ps2_clk_in  (ps2_clk_pin),
        .ps2_data_in (ps2_data_pin),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    int n_err = 0;

    logic [10:0] exp_frame = '0;
    int          frame_seq = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Line order: start(0), d0..d7, parity (makes the ones count odd), stop(1).
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic p;
        p = ($countones(b) % 2) == 0;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        exp_frame    = frame_of(b);
        frame_seq    = frame_seq + 1;
        hif.tx_data  = b;
        hif.tx_start = 1'b1;
        @(posedge clk);
        #1;
        hif.tx_start = 1'b0;
    endtask

    // Device: waits for request-to-send, then clocks n_edges bits at a 40-cycle period.
    task automatic dev_run(input int n_edges, input bit ack);
        int t;
        t = 0;
        while (!(ps2_data_oe && !ps2_clk_oe) && t < 100) begin
            cyc(1);
            t++;
        end
        if (t >= 100) begin
            chk("request_seen", 32'(ps2_data_oe), 32'd1);
            return;
        end
        cyc(HALF);
        for (int e = 1; e <= n_edges; e++) begin
            dev_clk = 1'b0;
            cyc(HALF);
            dev_clk = 1'b1;
            if (e == 10 && ack) begin
                cyc(HALF / 2);
                dev_data = 1'b0;
                cyc(HALF / 2);
            end else if (e == 11) begin
                cyc(2);
                dev_data = 1'b1;
                cyc(HALF - 2);
            end else begin
                cyc(HALF);
            end
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_pulse(input int base, input int limit, output int cycles);
        cycles = 0;
        while ((n_done + n_err) == base && cycles < limit) begin
            cyc(1);
            cycles++;
        end
    endtask

    // Compare process: rule checks every cycle plus frame bits at device clock edges.
    initial begin
        int   seen_seq;
        int   idx;
        int   run;
        logic prev_dclk;
        seen_seq  = 0;
        idx       = 0;
        run       = 0;
        prev_dclk = 1'b1;
        forever begin
            @(negedge clk);
            if (seen_seq != frame_seq) begin
                seen_seq = frame_seq;
                idx      = 0;
            end
            if (hif.done === 1'b1) n_done++;
            if (hif.error === 1'b1) n_err++;
            chk("done_with_error", 32'(hif.done & hif.error), 32'd0);
            if (hif.done || hif.error) chk("busy_during_pulse", 32'(hif.busy), 32'd0);
            if (!hif.busy) chk("lines_released_when_idle", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
            if (ps2_clk_oe) begin
                run++;
            end else if (run != 0) begin
                chk("inhibit_length", 32'(run), 32'(INH));
                run = 0;
            end
            if (frame_seq != 0) begin
                if (prev_dclk && !dev_clk && idx == 0) begin
                    chk("start_bit", 32'(ps2_data_pin), 32'(exp_frame[0]));
                    idx = 1;
                end else if (!prev_dclk && dev_clk && idx >= 1 && idx <= 10) begin
                    chk($sformatf("frame_bit%0d", idx), 32'(ps2_data_pin), 32'(exp_frame[idx]));
                    idx++;
                end
            end
            prev_dclk = dev_clk;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, c;
        hif.tx_data  = 8'h00;
        hif.tx_start = 1'b0;
        rst          = 1'b1;
        cyc(3);

        chk("rst_busy", 32'(hif.busy), 32'd0);
        chk("rst_done", 32'(hif.done), 32'd0);
        chk("rst_error", 32'(hif.error), 32'd0);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("model_frame_ed", 32'(frame_of(CMD_SET_LEDS)), 32'h7DA);
        chk("model_frame_f4", 32'(frame_of(CMD_ENABLE)), 32'h5E8);
        chk("model_frame_ff", 32'(frame_of(CMD_RESET)), 32'h7FE);
        rst = 1'b0;
        cyc(3);

        // 0xED with ACK
        d0 = n_done; e0 = n_err;
        send(CMD_SET_LEDS);
        chk("ed_busy_after_accept", 32'(hif.busy), 32'd1);
        dev_run(11, 1'b1);
        wait_pulse(d0 + e0, 500, c);
        cyc(3);
        chk("ed_done_count", 32'(n_done - d0), 32'd1);
        chk("ed_error_count", 32'(n_err - e0), 32'd0);
        chk("ed_busy_end", 32'(hif.busy), 32'd0);

        // 0xF4 with ACK
        d0 = n_done; e0 = n_err;
        send(CMD_ENABLE);
        dev_run(11, 1'b1);
        wait_pulse(d0 + e0, 500, c);
        cyc(3);
        chk("f4_done_count", 32'(n_done - d0), 32'd1);
        chk("f4_error_count", 32'(n_err - e0), 32'd0);

        // Missing ACK
        d0 = n_done; e0 = n_err;
        send(8'hA5);
        dev_run(11, 1'b0);
        wait_pulse(d0 + e0, 500, c);
        cyc(3);
        chk("nack_error_count", 32'(n_err - e0), 32'd1);
        chk("nack_done_count", 32'(n_done - d0), 32'd0);
        chk("nack_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

        // Device never clocks
        d0 = n_done; e0 = n_err;
        send(CMD_SET_LEDS);
        c = 0;
        while (hif.error !== 1'b1 && c < 400) begin
            cyc(1);
            c++;
        end
        if (c < 209 || c > 211) begin
            n_cmp++;
            n_bad++;
            $display("FAIL start_timeout_latency: got %0d cycles, expected 210 +-1", c);
        end else begin
            n_cmp++;
        end
        cyc(1);
        chk("timeout_data_oe", 32'(ps2_data_oe), 32'd0);
        cyc(3);
        chk("timeout_error_count", 32'(n_err - e0), 32'd1);
        chk("timeout_done_count", 32'(n_done - d0), 32'd0);

        // Reset after edge 5
        d0 = n_done; e0 = n_err;
        send(CMD_SET_LEDS);
        dev_run(5, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("abort_busy", 32'(hif.busy), 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(50);
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        chk("abort_no_error", 32'(n_err - e0), 32'd0);
        send(CMD_RESET);
        dev_run(11, 1'b1);
        wait_pulse(d0 + e0, 500, c);
        cyc(3);
        chk("after_abort_done", 32'(n_done - d0), 32'd1);
        chk("after_abort_error", 32'(n_err - e0), 32'd0);

        // tx_start during SHIFT is ignored
        d0 = n_done; e0 = n_err;
        send(CMD_SET_LEDS);
        fork
            dev_run(11, 1'b1);
            begin
                cyc(150);
                hif.tx_data  = 8'h00;
                hif.tx_start = 1'b1;
                cyc(1);
                hif.tx_start = 1'b0;
            end
        join
        wait_pulse(d0 + e0, 500, c);
        cyc(300);
        chk("ignored_start_done", 32'(n_done - d0), 32'd1);
        chk("ignored_start_error", 32'(n_err - e0), 32'd0);
        chk("ignored_start_idle", 32'(hif.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) from the FPGA to the keyboard over the shared PS2_clk/PS2_data lines.
- Complements the existing keyboard receive path; sits beside `keyboard_input` in `main`.
- Drives the open-drain lines through active-high pull-low enables. While `busy`, the top level masks the receiver.

Parameters:
- INHIBIT_CYCLES, 6000, clk cycles the host holds PS2_clk low before the request (120 us at 50 MHz).
- START_TIMEOUT, 750000, cycles allowed after the clock is released for the first device falling edge (15 ms).
- XFER_TIMEOUT, 100000, cycles allowed from the first device falling edge to ACK sampled (2 ms).
- CNT_W, 20, timer width; must hold the largest of the above.

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  asynchronous, active-high reset
- tx_data  input  8  command byte; sampled on an accepted tx_start
- tx_start  input  1  one-cycle request; accepted only in IDLE
- busy  output  1  high from the cycle after acceptance until return to IDLE
- done  output  1  one-cycle pulse: byte sent and device ACK seen
- error  output  1  one-cycle pulse: timeout or missing ACK
- ps2_clk_in  input  1  raw PS2_clk pin level
- ps2_data_in  input  1  raw PS2_data pin level
- ps2_clk_oe  output  1  1 = pull PS2_clk low, 0 = release
- ps2_data_oe  output  1  1 = pull PS2_data low, 0 = release

Behaviour:
- Reset (async, active-high): state=IDLE; busy, done, error, ps2_clk_oe and ps2_data_oe are all 0, so both lines are released immediately; timer, bit counter and shift register are cleared. Asserting rst mid-transfer aborts the transfer with no done or error pulse.
- Input sync: ps2_clk_in and ps2_data_in each pass through 2 flip-flops. A falling edge is detected when the previous synchronised clock is 1 and the current one is 0, giving 3 cycles of latency from the pin.
- Acceptance: tx_start=1 in IDLE latches tx_data and parity = ~^tx_data (odd parity), then enters INHIBIT. tx_start outside IDLE is ignored and does not queue.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles.
- REQUEST: ps2_data_oe=1 (start bit 0), ps2_clk_oe=0. Timer restarts at 0.
  - START_TIMEOUT cycles with no falling edge -> ERROR.
  - First falling edge -> drive data bit 0, enter SHIFT. Timer restarts for XFER_TIMEOUT.
- SHIFT: on falling edge k (k=1..8), drive data bit k-1 (ps2_data_oe = ~bit, LSB first).
  - Edge 9: drive parity.
  - Edge 10: release data (stop bit = 1), enter ACK.
- ACK: on edge 11, sample synchronised data. 0 -> WAIT_IDLE; 1 -> ERROR.
- WAIT_IDLE: wait until synchronised clock and data are both 1, then pulse done for 1 cycle and return to IDLE.
- XFER_TIMEOUT expiry in SHIFT, ACK or WAIT_IDLE -> ERROR.
- ERROR: release both lines, pulse error for 1 cycle, return to IDLE. It is never stuck.
- done and error are never high together. busy is 0 in the cycle done or error pulses.
- Timer saturates and does not wrap. Bit counter is 4 bits and counts falling edges 1..11.
- A falling edge in the same cycle the timeout expires: the edge wins.

Decomposition:
- Shared package ps2_pkg:
  - state enum: IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE, ERROR
  - default timing constants
  - common PS/2 command constants (CMD_SET_LEDS=0xED, CMD_ENABLE=0xF4, CMD_RESET=0xFF)
- Sub-module ps2_sync_edge: 2-FF synchroniser plus falling-edge detector, reusable by the receiver.

Test Plan (bench uses INHIBIT_CYCLES=10, START_TIMEOUT=200, XFER_TIMEOUT=2000; device model clocks at a 40-cycle period):
- tx_data=0xED, model ACKs -> ps2_clk_oe high for 10 cycles; data bits observed at rising edges are 0,1,0,1,1,0,1,1,1, parity=1, stop=1; done pulses once; busy then falls.
- tx_data=0xF4, model ACKs -> bits 0,0,1,0,1,1,1,1, parity=0; done=1, error=0.
- Model clocks 11 edges but leaves data high at the ACK edge -> error pulses once after edge 11; lines released; no done.
- Model never clocks -> error exactly START_TIMEOUT cycles after REQUEST entry, i.e. 210 cycles after acceptance (±1); ps2_data_oe=0 afterwards.
- rst asserted after edge 5 -> both oe go to 0 in the same cycle, busy=0, no pulses. A new 0xFF transfer afterwards completes with done.
- tx_start pulsed during SHIFT with tx_data=0x00 -> ignored; the in-flight 0xED bits are unchanged; exactly one done.
